// File: rtl/sgemm_mul8_rr_arbiter.sv
`timescale 1ns/1ps
// Purpose : round-robin share of one combinational 8x8->16 multiplier among NUM_REQ requesters.
// Latency : 1 cycle from accept edge to rsp_*; 1 op/cycle while the owner drains every cycle.
// Backpr. : single-entry result reg; no new grant while it is full and its owner holds rsp_ready low.
//
// Ports:
//   ap_clk/ap_rst_n           clock, async active-low reset
//   en                        gates new grants only (a held result still drains)
//   req_valid/req_ready       per-requester op handshake, ready is one-hot or zero
//   req_a/req_b/req_tag       packed per-requester operands and tag (requester i at slice i)
//   rsp_valid/rsp_ready       per-requester result handshake, valid one-hot on owner
//   rsp_data/rsp_tag          shared result bus
//   mul_din0/mul_din1/mul_dout external combinational multiplier
//   busy/op_count             status: activity flag and accepted-op counter
module sgemm_mul8_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DIN_WIDTH  = 8,
    parameter int DOUT_WIDTH = 16,
    parameter int TAG_WIDTH  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic                           en,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [DOUT_WIDTH-1:0]          rsp_data,
    output logic [TAG_WIDTH-1:0]           rsp_tag,
    output logic [DIN_WIDTH-1:0]           mul_din0,
    output logic [DIN_WIDTH-1:0]           mul_din1,
    input  logic [DOUT_WIDTH-1:0]          mul_dout,
    output logic                           busy,
    output logic [CNT_WIDTH-1:0]           op_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                  r_out_valid;
    logic [DOUT_WIDTH-1:0] r_out_data;
    logic [TAG_WIDTH-1:0]  r_out_tag;
    logic [IDX_W-1:0]      r_out_owner;
    logic [IDX_W-1:0]      r_ptr;
    logic [CNT_WIDTH-1:0]  r_op_count;

    logic                  w_slot_free;
    logic                  w_found;
    logic [IDX_W-1:0]      w_winner;
    logic [IDX_W:0]        w_cand;
    logic                  w_grant;
    logic [IDX_W-1:0]      w_ptr_nxt;
    logic [DIN_WIDTH-1:0]  w_a;
    logic [DIN_WIDTH-1:0]  w_b;
    logic [TAG_WIDTH-1:0]  w_tag;
    logic [NUM_REQ-1:0]    w_ready;
    logic [NUM_REQ-1:0]    w_rsp_valid;

    // The output slot can be refilled in the same cycle its owner drains it.
    assign w_slot_free = !r_out_valid || rsp_ready[r_out_owner];

    // Rotating priority search starting at r_ptr; first valid requester wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_cand[IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[IDX_W-1:0];
            end
        end
    end

    // Reset term keeps req_ready low while the block is held in reset.
    assign w_grant = ap_rst_n && en && w_slot_free && w_found;

    assign w_ptr_nxt = (w_winner == IDX_W'(NUM_REQ-1)) ? '0 : w_winner + 1'b1;

    // Operand/tag mux and one-hot ready; everything is zero when nobody wins.
    always_comb begin
        w_a     = '0;
        w_b     = '0;
        w_tag   = '0;
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant && (w_winner == IDX_W'(i))) begin
                w_a        = req_a[i*DIN_WIDTH +: DIN_WIDTH];
                w_b        = req_b[i*DIN_WIDTH +: DIN_WIDTH];
                w_tag      = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                w_ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_rsp_valid = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_rsp_valid[j] = r_out_valid && (r_out_owner == IDX_W'(j));
        end
    end

    // Result register. Data/tag are only written on accept so the bus keeps
    // its last value after a drain.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_owner <= '0;
            r_ptr       <= '0;
            r_op_count  <= '0;
        end else begin
            if (w_grant) begin
                r_out_valid <= 1'b1;
                r_out_data  <= mul_dout;
                r_out_tag   <= w_tag;
                r_out_owner <= w_winner;
                r_ptr       <= w_ptr_nxt;
                r_op_count  <= r_op_count + 1'b1;
            end else if (r_out_valid && rsp_ready[r_out_owner]) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign req_ready = w_ready;
    assign mul_din0  = w_a;
    assign mul_din1  = w_b;
    assign rsp_valid = w_rsp_valid;
    assign rsp_data  = r_out_data;
    assign rsp_tag   = r_out_tag;
    assign busy      = r_out_valid || (|req_valid);
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_sgemm_mul8_rr_arbiter.sv
`timescale 1ns/1ps
module tb_sgemm_mul8_rr_arbiter;

    localparam int N = 4;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        en;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [15:0] req_tag;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic [7:0]  mul_din0;
    logic [7:0]  mul_din1;
    logic [15:0] mul_dout;
    logic        busy;
    logic [31:0] op_count;

    // Second instance with a narrow counter so wrap-around is reachable quickly.
    logic [3:0]  req_ready2;
    logic [3:0]  rsp_valid2;
    logic [15:0] rsp_data2;
    logic [3:0]  rsp_tag2;
    logic [7:0]  mul_din0_2;
    logic [7:0]  mul_din1_2;
    logic [15:0] mul_dout2;
    logic        busy2;
    logic [7:0]  op_count2;

    always #5 ap_clk = ~ap_clk;

    // Behavioural multipliers
    assign mul_dout  = {8'd0, mul_din0}   * {8'd0, mul_din1};
    assign mul_dout2 = {8'd0, mul_din0_2} * {8'd0, mul_din1_2};

    sgemm_mul8_rr_arbiter dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .busy(busy), .op_count(op_count)
    );

    sgemm_mul8_rr_arbiter #(.CNT_WIDTH(8)) dut2 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .en(en),
        .req_valid(req_valid), .req_ready(req_ready2),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data2), .rsp_tag(rsp_tag2),
        .mul_din0(mul_din0_2), .mul_din1(mul_din1_2), .mul_dout(mul_dout2),
        .busy(busy2), .op_count(op_count2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_pend;
    int          m_owner;
    int          m_ptr;
    logic [15:0] m_data;
    logic [3:0]  m_tag;
    logic [31:0] m_count;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_data  = '0;
        m_tag   = '0;
        m_count = '0;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
        req_a[i*8 +: 8]   = a;
        req_b[i*8 +: 8]   = b;
        req_tag[i*4 +: 4] = t;
    endtask

    task automatic rand_ops();
        req_a   = $urandom;
        req_b   = $urandom;
        req_tag = 16'($urandom);
    endtask

    // One clock cycle: called just after a falling edge with inputs already driven.
    task automatic step();
        bit          slot;
        int          win;
        int          idx;
        logic [3:0]  exp_rdy;
        logic [3:0]  exp_rv;
        logic [7:0]  ea;
        logic [7:0]  eb;
        #1;
        slot = !m_pend || rsp_ready[m_owner];
        win  = -1;
        if (en && slot) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (win < 0 && req_valid[idx]) win = idx;
            end
        end
        exp_rdy = (win >= 0) ? (4'b0001 << win) : 4'b0000;
        exp_rv  = m_pend ? (4'b0001 << m_owner) : 4'b0000;
        ea = (win >= 0) ? req_a[win*8 +: 8] : 8'd0;
        eb = (win >= 0) ? req_b[win*8 +: 8] : 8'd0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("rsp_data",  32'(rsp_data),  32'(m_data));
        chk("rsp_tag",   32'(rsp_tag),   32'(m_tag));
        chk("mul_din0",  32'(mul_din0),  32'(ea));
        chk("mul_din1",  32'(mul_din1),  32'(eb));
        chk("busy",      32'(busy),      32'(m_pend || (|req_valid)));
        chk("op_count",  op_count,       m_count);
        chk("op_count8", 32'(op_count2), 32'(m_count[7:0]));
        if (win >= 0) begin
            m_pend  = 1'b1;
            m_data  = 16'(int'(ea) * int'(eb));
            m_tag   = req_tag[win*4 +: 4];
            m_owner = win;
            m_ptr   = (win + 1) % N;
            m_count = m_count + 1;
        end else if (m_pend && rsp_ready[m_owner]) begin
            m_pend = 1'b0;
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    // Asynchronous reset pulse asserted between clock edges.
    task automatic async_reset();
        #2 ap_rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_op_count",  op_count,       32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        model_reset();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    initial begin
        ap_rst_n  = 1'b0;
        en        = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        model_reset();
        repeat (2) @(negedge ap_clk);
        #1;
        // Reset state; req_valid is high to show ready is held low in reset
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data",  32'(rsp_data),  32'd0);
        chk("reset_rsp_tag",   32'(rsp_tag),   32'd0);
        chk("reset_op_count",  op_count,       32'd0);
        @(negedge ap_clk);
        ap_rst_n  = 1'b1;
        req_valid = 4'b0000;
        step();

        // Single op from requester 0
        set_op(0, 8'd3, 8'd5, 4'd1);
        req_valid = 4'b0001;
        #1 chk("t1_req_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0000;
        #1;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'b0001);
        chk("t1_rsp_data",  32'(rsp_data),  32'd15);
        chk("t1_rsp_tag",   32'(rsp_tag),   32'd1);
        chk("t1_op_count",  op_count,       32'd1);
        step();

        // All requesters continuously valid: one grant per cycle in rotation
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            rand_ops();
            step();
        end
        req_valid = 4'b0000;
        step();

        // Back-pressure held by requester 2 for three cycles
        set_op(2, 8'd255, 8'd255, 4'd7);
        req_valid = 4'b0100;
        step();
        rsp_ready = 4'b1011;
        req_valid = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t3_rsp_data",  32'(rsp_data),  32'hFE01);
            chk("t3_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 4'b1111;
        step();
        req_valid = 4'b0000;
        step();

        // en=0: pending result still drains, no new grant until en returns
        set_op(0, 8'd9, 8'd11, 4'd3);
        set_op(1, 8'd12, 8'd13, 4'd4);
        req_valid = 4'b0001;
        step();
        en        = 1'b0;
        req_valid = 4'b0010;
        step();
        step();
        en = 1'b1;
        #1 chk("t4_req_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b0000;
        step();

        // Reset while a result is held; it must never be returned
        req_valid = 4'b1111;
        rsp_ready = 4'b0000;
        rand_ops();
        step();
        step();
        async_reset();
        req_valid = 4'b0000;
        rsp_ready = 4'b1111;
        step();
        step();
        req_valid = 4'b1111;
        #1 chk("t5_grant_after_rst", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0000;
        step();

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            en        = ($urandom_range(0, 7) != 0);
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
            rand_ops();
            step();
        end

        // Counter wrap on the 8-bit-counter instance
        en        = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 4'b1111;
        step();
        async_reset();
        req_valid = 4'b1111;
        for (int c = 0; c < 256; c++) begin
            rand_ops();
            step();
        end
        #1;
        chk("t6_wrap_count8",  32'(op_count2), 32'd0);
        chk("t6_count32",      op_count,       32'd256);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
